stream_in_fifo: RTL

Parameterised synchronous FIFO sitting directly upstream of the sample stream block. It accepts bytes from a testbench-driven write port and presents them on a valid/ready stream interface that connects straight to the downstream `stream_in_valid` / `stream_in_ready` / `stream_in_data` ports. It buffers and absorbs backpressure, so cocotb tests can exercise stalls, bursts and flushes against the downstream stage.

---
 rtl/stream_in_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_in_fifo.sv
// stream_in_fifo: power-of-two synchronous FIFO feeding the sample stream
// block over a valid/ready interface, with optional handshake statistics.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   wr_valid/wr_ready  write handshake, wr_data payload
//   flush              synchronous discard of all entries
//   stream_in_valid/stream_in_ready/stream_in_data  output stream
//   level              occupancy 0..DEPTH
//   xfer_count         read handshakes (wrapping), 0 unless stats enabled
//   stall_count        valid && !ready cycles (saturating), 0 unless enabled
//
// Define STREAM_IN_FIFO_STATS_EN to build the two statistics counters.

module stream_in_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       flush,
  output logic                       stream_in_valid,
  input  logic                       stream_in_ready,
  output logic [DATA_WIDTH-1:0]      stream_in_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                xfer_count,
  output logic [15:0]                stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic wr_fire;
  logic rd_fire;

  // Status comes only from registered occupancy, so a same-cycle read
  // never opens a full FIFO and a same-cycle write never bypasses.
  assign wr_ready        = (level_q != LW'(DEPTH));
  assign stream_in_valid = (level_q != '0);
  assign stream_in_data  = mem_q[rd_ptr_q];
  assign level           = level_q;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = stream_in_valid && stream_in_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef STREAM_IN_FIFO_STATS_EN
  logic [15:0] xfer_q, xfer_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    // A read squashed by flush is not a transfer.
    if (rd_fire && !flush) xfer_d = xfer_q + 16'd1;
    if (stream_in_valid && !stream_in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end

  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;
`else
  assign xfer_count  = '0;
  assign stall_count = '0;
`endif

endmodule
